// File: rtl/rf_write_sched.sv
// Y86-64 register-file write-port scheduler: serialises write-back updates
// and debug writes onto one registered write port.
module rf_write_sched #(
    parameter int STARVE_LIM = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wb_valid,
    output logic        o_wb_ready,
    input  logic [3:0]  i_icode,
    input  logic        i_cnd,
    input  logic [3:0]  i_ra,
    input  logic [3:0]  i_rb,
    input  logic [63:0] i_vale,
    input  logic [63:0] i_valm,
    input  logic        i_dbg_req,
    input  logic [3:0]  i_dbg_addr,
    input  logic [63:0] i_dbg_data,
    output logic        o_dbg_gnt,
    output logic        o_we,
    output logic [3:0]  o_waddr,
    output logic [63:0] o_wdata,
    output logic        o_busy
);

    typedef enum logic {S_IDLE, S_WR2} state_t;

    localparam logic [2:0] LIM   = 3'(STARVE_LIM);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    state_t      r_state;
    logic [2:0]  r_starve;
    logic [3:0]  r_pend_addr;
    logic [63:0] r_pend_data;

    logic        w_idle;
    logic        w_force;
    logic        w_acc;
    logic        w_wr_en;
    logic [3:0]  w_wr_addr;
    logic [63:0] w_wr_data;
    logic        w_pop;

    assign w_idle     = (r_state == S_IDLE);
    assign w_force    = (r_starve >= LIM);
    assign o_wb_ready = !i_rst && w_idle && !w_force;
    assign o_dbg_gnt  = !i_rst && w_idle && i_dbg_req && (!i_wb_valid || w_force);
    assign w_acc      = i_wb_valid && o_wb_ready;
    assign o_busy     = (r_state == S_WR2);

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = i_rb;
        w_wr_data = i_vale;
        w_pop     = 1'b0;
        case (i_icode)
            4'h2: w_wr_en = i_cnd;
            4'h3, 4'h6: w_wr_en = 1'b1;
            4'h5: begin
                w_wr_en   = 1'b1;
                w_wr_addr = i_ra;
                w_wr_data = i_valm;
            end
            4'h8, 4'h9, 4'hA: begin
                w_wr_en   = 1'b1;
                w_wr_addr = RRSP;
            end
            // popq: %rsp first so that a popq %rsp ends with valM
            4'hB: begin
                w_wr_en   = 1'b1;
                w_wr_addr = RRSP;
                w_pop     = (i_ra != RNONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_starve    <= 3'd0;
            r_pend_addr <= 4'd0;
            r_pend_data <= 64'd0;
            o_we        <= 1'b0;
            o_waddr     <= 4'd0;
            o_wdata     <= 64'd0;
        end else begin
            o_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        if (w_wr_en && w_wr_addr != RNONE) begin
                            o_we    <= 1'b1;
                            o_waddr <= w_wr_addr;
                            o_wdata <= w_wr_data;
                        end
                        if (w_pop) begin
                            r_state     <= S_WR2;
                            r_pend_addr <= i_ra;
                            r_pend_data <= i_valm;
                        end
                    end else if (o_dbg_gnt && i_dbg_addr != RNONE) begin
                        o_we    <= 1'b1;
                        o_waddr <= i_dbg_addr;
                        o_wdata <= i_dbg_data;
                    end
                end
                S_WR2: begin
                    o_we    <= 1'b1;
                    o_waddr <= r_pend_addr;
                    o_wdata <= r_pend_data;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (o_dbg_gnt || !i_dbg_req)
                r_starve <= 3'd0;
            else if (w_acc && r_starve != 3'd7)
                r_starve <= r_starve + 3'd1;
        end
    end

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Register-file write-port scheduler for the Y86-64 write-back stage. It accepts one retiring instruction per handshake, decodes from `icode` which registers to update, and serialises those updates onto a single registered write port (`we`/`waddr`/`wdata`). A debug/initialisation requester shares the same port under fixed priority with anti-starvation. Two-register updates (popq) are split into two consecutive writes, ordered so the architectural result is correct.

## Interface
- `STARVE_LIM`, default 4: consecutive WB acceptances with `dbg_req` pending before the debug port is forced in.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_valid`  in  1  write-back stage presents an instruction.
- `wb_ready`  out  1  scheduler can accept; a transfer occurs on an edge where `wb_valid & wb_ready`.
- `icode`  in  4  instruction code.
- `cnd`  in  1  condition flag; qualifies cmov only.
- `rA`, `rB`  in  4 each  register IDs; 4'hF means no register.
- `valE`, `valM`  in  64 each  ALU result and memory result.
- `dbg_req`  in  1  debug write request, held until granted.
- `dbg_addr`  in  4  debug target register.
- `dbg_data`  in  64  debug write data.
- `dbg_gnt`  out  1  combinational; debug write accepted this cycle.
- `we`  out  1  registered register-file write enable.
- `waddr`  out  4  registered write address.
- `wdata`  out  64  registered write data.
- `busy`  out  1  high in state WR2.

## Operation
- States: IDLE, WR2. WR2 holds the pending second write (`rA`, `valM` captured at acceptance).
- Decode on accept:
  - icode 6 (OPq) and 3 (irmovq): write rB←valE.
  - icode 2 (cmovXX): write rB←valE only if `cnd`=1.
  - icode 8, 9, 10 (call, ret, pushq): write 4 (%rsp)←valE.
  - icode 5 (mrmovq): write rA←valM.
  - icode 11 (popq): first write 4←valE; then rA←valM in WR2. When rA=4, the later write wins, so %rsp ends as valM.
  - All other icodes: accepted, no write.
- Any write whose target is 4'hF is suppressed (`we`=0). A popq with rA=F makes no transition to WR2.
- `wb_ready` = !rst & state==IDLE & !force, where force = (starve_cnt ≥ STARVE_LIM).
- `dbg_gnt` = !rst & state==IDLE & dbg_req & (!wb_valid | force). A grant loads `we`=1, `waddr`=dbg_addr, `wdata`=dbg_data. A dbg_addr of F is suppressed.
- WB and debug are never granted in the same cycle.
- starve_cnt (3-bit, saturating):
  - +1 on each WB acceptance while `dbg_req`=1.
  - Cleared on `dbg_gnt` or whenever `dbg_req`=0.
- In WR2: no acceptance and no grant. The next edge emits the rA write and returns to IDLE.
- Cycles with no grant or acceptance load `we`=0; `waddr`/`wdata` hold their values.

## Timing
- Reset (asynchronous, immediate):
  - `we`=0, `waddr`=0, `wdata`=0.
  - state=IDLE, starve_cnt=0.
  - `busy`=0; `wb_ready`=0 and `dbg_gnt`=0 while rst is high.
- Latency is 1 cycle: a transfer on edge N drives the write from edge N to edge N+1.
- popq accepted at edge N:
  - %rsp write in cycle N..N+1, rA write in cycle N+1..N+2.
  - `wb_ready`=0 and `busy`=1 during N..N+1.
  - Earliest next acceptance is edge N+2.
- Sustained single-write instructions: one per cycle, `we` high every cycle.
- Reset asserted in WR2 drops the pending rA write.

## Test plan
- Reset then irmovq (icode 3, rB=2, valE=64'h10), one handshake → next cycle `we`=1, `waddr`=2, `wdata`=64'h10; following cycle `we`=0.
- popq with rA=3, valE=64'h100, valM=64'hAB → write 4←64'h100, then 3←64'hAB on the next cycle. `wb_ready` is low for exactly one cycle. Repeat with rA=4: the final %rsp write is 64'hAB.
- cmov (icode 2, rB=5) with cnd=0 → `we` stays 0; with cnd=1 → `waddr`=5 written with valE. mrmovq with rA=F → no write.
- `wb_valid` held high with back-to-back OPq while `dbg_req`=1 (addr 7, data 64'h55) → 4 WB writes, then `wb_ready`=0 for one cycle, then `dbg_gnt`=1 and write 7←64'h55. WB resumes the next cycle.
- `dbg_req` while `wb_valid`=0 → immediate `dbg_gnt`; write appears the next cycle.
- Assert `rst` mid-cycle during WR2 → `we`=0 immediately, no rA write after release; first handshake after release behaves as from reset.
